// File: rtl/fanout_settle_monitor.sv
// fanout_settle_monitor: times how long NCH buffered/inverted copies of src take to settle after each src change
module fanout_settle_monitor #(
  parameter int WIDTH      = 8,
  parameter int NCH        = 4,
  parameter int SETTLE_MAX = 3,
  parameter int CNT_W      = 4,
  localparam int LW        = $clog2(SETTLE_MAX + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       src,
  input  logic [NCH*WIDTH-1:0]   obs,
  input  logic [NCH-1:0]         inv_mask,
  input  logic                   clr,
  output logic                   busy,
  output logic                   settled,
  output logic [LW-1:0]          settle_lat,
  output logic                   timeout,
  output logic [NCH-1:0]         err_ch,
  output logic                   err_sticky,
  output logic [NCH*CNT_W-1:0]   mis_cnt
);
  typedef enum logic {IDLE, SETTLE} state_t;
  state_t               state_q, state_d;
  logic [WIDTH-1:0]     src_q;
  logic [LW-1:0]        elapsed_q, elapsed_d, lat_q, lat_d;
  logic                 settled_q, settled_d, timeout_q, timeout_d, sticky_q, sticky_d;
  logic [NCH-1:0]       err_ch_q, err_ch_d, mis;
  logic [NCH*CNT_W-1:0] cnt_q, cnt_d;
  logic                 chg;
  // 4-state compares so X/Z on src or any copy counts as a change/mismatch in simulation
  always_comb begin
    chg = src !== src_q;
    mis = '0;
    for (int k = 0; k < NCH; k++)
      mis[k] = !(obs[k*WIDTH +: WIDTH] === (inv_mask[k] ? ~src_q : src_q));
  end
  always_comb begin
    state_d   = state_q;
    elapsed_d = elapsed_q;
    lat_d     = lat_q;
    settled_d = 1'b0;
    timeout_d = 1'b0;
    err_ch_d  = clr ? '0 : err_ch_q;
    sticky_d  = clr ? 1'b0 : sticky_q;
    if (state_q == IDLE) begin
      if (chg) begin
        state_d   = SETTLE;
        elapsed_d = '0;
      end
    end else if (chg) begin
      elapsed_d = '0;
    end else if (~|mis) begin
      settled_d = 1'b1;
      lat_d     = elapsed_q;
      state_d   = IDLE;
    end else if (elapsed_q == LW'(SETTLE_MAX - 1)) begin
      timeout_d = 1'b1;
      err_ch_d  = mis;
      sticky_d  = 1'b1;
      state_d   = IDLE;
    end else begin
      elapsed_d = elapsed_q + 1'b1;
    end
  end
  // a simultaneous clr zeroes the base first, so a timeout still lands its increment
  always_comb begin
    cnt_d = '0;
    for (int k = 0; k < NCH; k++) begin
      cnt_d[k*CNT_W +: CNT_W] = clr ? '0 : cnt_q[k*CNT_W +: CNT_W];
      if (timeout_d && mis[k] && !(&cnt_d[k*CNT_W +: CNT_W]))
        cnt_d[k*CNT_W +: CNT_W] = cnt_d[k*CNT_W +: CNT_W] + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    src_q <= src;
    if (!rst_n) begin
      state_q   <= IDLE;
      elapsed_q <= '0;
      lat_q     <= '0;
      settled_q <= 1'b0;
      timeout_q <= 1'b0;
      err_ch_q  <= '0;
      sticky_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      elapsed_q <= elapsed_d;
      lat_q     <= lat_d;
      settled_q <= settled_d;
      timeout_q <= timeout_d;
      err_ch_q  <= err_ch_d;
      sticky_q  <= sticky_d;
      cnt_q     <= cnt_d;
    end
  end
  assign busy       = state_q == SETTLE;
  assign settled    = settled_q;
  assign settle_lat = lat_q;
  assign timeout    = timeout_q;
  assign err_ch     = err_ch_q;
  assign err_sticky = sticky_q;
  assign mis_cnt    = cnt_q;
endmodule
